// File: rtl/background_redraw_pkg.sv
// Shared constants and state encoding for the background raster redraw block.
package background_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_e;
endpackage

// File: rtl/background_redraw_if.sv
// Fetch port toward getBackgroundPixel and write port toward the VGA adapter.
interface background_redraw_if;
  import background_pkg::*;

  logic                start;
  logic                hold;
  logic [COLOUR_W-1:0] bg_color;
  logic [X_W-1:0]      bg_x;
  logic [Y_W-1:0]      bg_y;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    input  start, hold, bg_color,
    output bg_x, bg_y, vga_x, vga_y, vga_colour, plot, busy, done
  );
  modport slave (
    output start, hold, bg_color,
    input  bg_x, bg_y, vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/background_redraw_raster_counter.sv
// Row-major screen coordinate counter with synchronous clear and last-pixel flag.
module raster_counter
  import background_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           en,
  input  logic           clr,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);
  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic           x_end, y_end;

  assign x_end = (cx_q == X_W'(SCREEN_W - 1));
  assign y_end = (cy_q == Y_W'(SCREEN_H - 1));
  assign last  = x_end && y_end;
  assign cx    = cx_q;
  assign cy    = cy_q;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en) begin
      if (x_end) begin
        cx_d = '0;
        // Wrapping cy at frame end keeps the counter in range; nothing uses it after.
        cy_d = y_end ? '0 : cy_q + Y_W'(1);
      end else begin
        cx_d = cx_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end
endmodule

// File: rtl/background_redraw.sv
// Full-screen background repaint: sweeps all coordinates, hides the one-cycle
// ROM latency with a pending register, and stalls cleanly under hold.
module background_redraw
  import background_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  background_redraw_if.master  bus
);
  state_e         state_q, state_d;
  logic [X_W-1:0] px_q, px_d;
  logic [Y_W-1:0] py_q, py_d;
  logic           pvalid_q, pvalid_d;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           last, cnt_en, cnt_clr, step;

  assign step    = !bus.hold;
  assign cnt_en  = (state_q == SWEEP) && step;
  assign cnt_clr = (state_q == IDLE) && bus.start;

  raster_counter u_cnt (
    .clock  (clock),
    .resetn (resetn),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .cx     (cx),
    .cy     (cy),
    .last   (last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      px_q     <= '0;
      py_q     <= '0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      pvalid_q <= pvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    pvalid_d = pvalid_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = SWEEP;
      SWEEP: if (step) begin
        px_d     = cx;
        py_d     = cy;
        pvalid_d = 1'b1;
        if (last) state_d = FLUSH;
      end
      FLUSH: if (step) begin
        pvalid_d = 1'b0;
        state_d  = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // During a stall re-fetch the pending pixel so its colour is ready on release.
    if (bus.hold && pvalid_q) begin
      bus.bg_x = px_q;
      bus.bg_y = py_q;
    end else begin
      bus.bg_x = cx;
      bus.bg_y = cy;
    end
    bus.vga_x      = px_q;
    bus.vga_y      = py_q;
    bus.vga_colour = bus.bg_color;
    bus.plot       = pvalid_q && !bus.hold;
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == DONE);
  end
endmodule

// File: tb/tb_background_redraw.sv
// Directed bench: one full sweep with stalls and a stray start, then a mid-sweep reset.
module tb_background_redraw;
  localparam int N      = 320 * 240;
  localparam int IDX_A  = 50 * 320 + 100;
  localparam int IDX_B  = 10 * 320 + 319;
  localparam int LIMIT  = 80000;

  logic clock = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errs   = 0;
  int   cyc, loaded, plotted, nplots, ha, hb, first_cyc, last_cyc;

  background_redraw_if bus();

  background_redraw dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // getBackgroundPixel stand-in: synchronous ROM, colour = (x ^ y) & 7
  always @(posedge clock) bus.bg_color <= 3'(bus.bg_x ^ {1'b0, bus.bg_y});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    loaded = 0; plotted = 0; nplots = 0; ha = 0; hb = 0;
    first_cyc = -1; last_cyc = -1;
  endtask

  // Called just after a rising edge; drives this cycle's hold, checks at negedge.
  task automatic step(input logic h, input logic st);
    int x, y;
    logic exp_plot;
    bus.hold  = h;
    bus.start = st;
    @(negedge clock);
    exp_plot = (loaded > plotted) && !h;
    chk("plot", 32'(bus.plot), 32'(exp_plot));
    chk("busy_done", {30'd0, bus.busy, bus.done}, 32'b10);
    if (bus.plot) nplots++;
    if (exp_plot) begin
      x = plotted % 320;
      y = plotted / 320;
      chk("pixel", {12'd0, bus.vga_x, bus.vga_y, bus.vga_colour},
          {12'd0, 9'(x), 8'(y), 3'((x ^ y) & 7)});
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (h) begin
      if (loaded > plotted && plotted == IDX_A) ha++;
      if (loaded > plotted && plotted == IDX_B) hb++;
    end else begin
      if (exp_plot) plotted++;
      if (loaded < N) loaded++;
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic kick();
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    cyc = 1;
  endtask

  initial begin
    logic h;
    resetn = 1'b0; bus.start = 1'b0; bus.hold = 1'b0;
    cyc = 0;
    model_reset();
    #1;
    chk("rst_outs", {27'd0, bus.plot, bus.busy, bus.done, 2'b00}, 32'd0);
    chk("rst_addr", {15'd0, bus.bg_x, bus.bg_y}, 32'd0);
    chk("rst_vga", {15'd0, bus.vga_x, bus.vga_y}, 32'd0);
    @(negedge clock); resetn = 1'b1;

    // Sweep 1: hold cycles 1..3, 5-cycle stall at (100,50), 2-cycle at (319,10), start at 500
    kick();
    while (plotted < N && cyc < LIMIT) begin
      h = (cyc <= 3) ||
          (loaded > plotted && plotted == IDX_A && ha < 5) ||
          (loaded > plotted && plotted == IDX_B && hb < 2);
      step(h, cyc == 500);
    end
    chk("timeout1", 32'(plotted), 32'(N));
    bus.hold = 1'b0; bus.start = 1'b0;
    @(negedge clock);
    chk("done_pulse", {30'd0, bus.busy, bus.done}, 32'b11);
    chk("done_plot", 32'(bus.plot), 32'd0);
    chk("done_cycle", 32'(cyc), 32'd76812);
    @(posedge clock); #1 cyc++;
    @(negedge clock);
    chk("after_done", {29'd0, bus.busy, bus.done, bus.plot}, 32'd0);
    chk("first_plot_cyc", 32'(first_cyc), 32'd5);
    chk("last_plot_cyc", 32'(last_cyc), 32'd76811);
    chk("plot_count", 32'(nplots), 32'(N));
    chk("stall_a", 32'(ha), 32'd5);
    chk("stall_b", 32'(hb), 32'd2);

    // Sweep 2: reset once 1000 pixels are out
    model_reset();
    kick();
    while (plotted < 1000 && cyc < 2000) step(1'b0, 1'b0);
    chk("timeout2", 32'(plotted), 32'd1000);
    resetn = 1'b0;
    #1;
    chk("midrst_outs", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
    chk("midrst_addr", {15'd0, bus.bg_x, bus.bg_y}, 32'd0);
    @(negedge clock); resetn = 1'b1;

    // Sweep 3: must restart cleanly from (0,0)
    model_reset();
    kick();
    repeat (12) step(1'b0, 1'b0);
    chk("restart_first", 32'(first_cyc), 32'd2);
    chk("restart_count", 32'(nplots), 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
